// File: rtl/onchip_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Each owner may hold the RAM for at most MAX_BURST accepts while the other master waits.
module onchip_memory_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state, state_next;
    logic             last_grant, last_grant_next;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_next;
    logic             req0, req1;
    logic             grant0, grant1;
    logic             rvalid_pipe0, rvalid_pipe1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Grants are gated by reset_n so both masters see waitrequest while reset is held.
    always_comb begin
        grant0          = 1'b0;
        grant1          = 1'b0;
        state_next      = IDLE;
        last_grant_next = last_grant;
        burst_cnt_next  = '0;
        case (state)
            OWN0: begin
                if (req0 && ((burst_cnt < MAX_CNT) || !req1)) grant0 = 1'b1;
                else if (req1)                                grant1 = 1'b1;
            end
            OWN1: begin
                if (req1 && ((burst_cnt < MAX_CNT) || !req0)) grant1 = 1'b1;
                else if (req0)                                grant0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    grant0 = last_grant;
                    grant1 = !last_grant;
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end
            end
        endcase
        grant0 = grant0 & reset_n;
        grant1 = grant1 & reset_n;

        if (grant0) begin
            state_next      = OWN0;
            last_grant_next = 1'b0;
            if (state == OWN0)
                burst_cnt_next = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
            else
                burst_cnt_next = CNT_W'(1);
        end else if (grant1) begin
            state_next      = OWN1;
            last_grant_next = 1'b1;
            if (state == OWN1)
                burst_cnt_next = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
            else
                burst_cnt_next = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            burst_cnt    <= '0;
            rvalid_pipe0 <= 1'b0;
            rvalid_pipe1 <= 1'b0;
        end else begin
            state        <= state_next;
            last_grant   <= last_grant_next;
            burst_cnt    <= burst_cnt_next;
            rvalid_pipe0 <= grant0 & m0_read & !m0_write;
            rvalid_pipe1 <= grant1 & m1_read & !m1_write;
        end
    end

    always_comb begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_write      = 1'b0;
        if (grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end else if (grant0) begin
            mem_write      = m0_write;
        end
    end

    assign mem_chipselect   = grant0 | grant1;
    assign mem_clken        = 1'b1;
    assign m0_waitrequest   = !grant0;
    assign m1_waitrequest   = !grant1;
    assign m0_readdatavalid = rvalid_pipe0;
    assign m1_readdatavalid = rvalid_pipe1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule
